// File: rtl/fft_addr_pkg.sv
// Shared types and width helpers for the FFT butterfly address generator.
// Widths derive from ADDR_WIDTH so the top and the address map agree on field sizes.
package fft_addr_pkg;

   typedef enum logic {
      MODE_DIT = 1'b0,
      MODE_DIF = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   // Stage numbers run 0..aw-1.
   function automatic int stage_w(input int aw);
      return (aw > 1) ? $clog2(aw) : 1;
   endfunction

   // log_n runs 0..aw inclusive.
   function automatic int logn_w(input int aw);
      return $clog2(aw + 1);
   endfunction

endpackage

// File: rtl/fft_addr_map.sv
// Combinational butterfly map: (b, s, log_n, mode) -> operand addresses, twiddle index, group flag.
// No state, no handshake; the caller registers the results.
module fft_addr_map
   import fft_addr_pkg::*;
#(
   parameter int AW = 13
) (
   input  logic [AW-2:0]           b,
   input  logic [stage_w(AW)-1:0]  s,
   input  logic [logn_w(AW)-1:0]   log_n,
   input  mode_e                   mode,
   output logic [AW-1:0]           addr_a,
   output logic [AW-1:0]           addr_b,
   output logic [AW-2:0]           tw_idx,
   output logic                    group_last
);

   localparam int SW = stage_w(AW);

   logic [SW-1:0] p;
   logic [AW-1:0] bx;
   logic [AW-1:0] bit_p;
   logic [AW-1:0] mask;
   logic [AW-2:0] j;
   logic [31:0]   sh;

   always_comb begin
      p      = '0;
      sh     = '0;
      if (mode == MODE_DIT) begin
         p  = s;
         sh = 32'(AW - 1) - 32'(s);
      end else begin
         p  = SW'(32'(log_n) - 32'd1 - 32'(s));
         sh = 32'(s) + 32'(AW) - 32'(log_n);
      end
      bit_p  = AW'(1) << p;
      mask   = bit_p - AW'(1);
      bx     = {1'b0, b};
      // Open a zero at bit p: bits above p shift up by one, bits below stay put.
      addr_a = ((bx & ~mask) << 1) | (bx & mask);
      addr_b = addr_a | bit_p;
      j      = b & mask[AW-2:0];
      tw_idx = j << sh;
      group_last = (j == mask[AW-2:0]);
   end

endmodule

// File: rtl/fft_addr_gen.sv
// Sequential radix-2 FFT butterfly address generator with DIT/DIF ordering and inter-stage gap.
// First beat one cycle after start; all outputs registered and held while out_ready is low.
module fft_addr_gen
   import fft_addr_pkg::*;
#(
   parameter int ADDR_WIDTH = 13,
   parameter int STAGE_GAP  = 0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic [logn_w(ADDR_WIDTH)-1:0]       log_n,
   input  logic                                mode,
   output logic                                busy,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [ADDR_WIDTH-1:0]               addr_a,
   output logic [ADDR_WIDTH-1:0]               addr_b,
   output logic [ADDR_WIDTH-2:0]               tw_idx,
   output logic [stage_w(ADDR_WIDTH)-1:0]      stage,
   output logic                                group_last,
   output logic                                out_last,
   output logic                                done
);

   localparam int LW = logn_w(ADDR_WIDTH);
   localparam int SW = stage_w(ADDR_WIDTH);
   localparam int BW = ADDR_WIDTH - 1;
   localparam int GW = 8;

   state_e          state_q, state_d;
   logic [BW-1:0]   b_q, b_d;
   logic [SW-1:0]   s_q, s_d;
   logic [LW-1:0]   ln_q, ln_d;
   mode_e           mode_q, mode_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic            valid_q, valid_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q;
   logic [BW-1:0]         tw_idx_q;
   logic [SW-1:0]         stage_q;
   logic                  group_last_q, out_last_q;

   logic [BW-1:0] last_b_q, last_b_d;
   logic [SW-1:0] last_s_q, last_s_d;

   logic [ADDR_WIDTH-1:0] map_a, map_b;
   logic [BW-1:0]         map_tw;
   logic                  map_gl;

   fft_addr_map #(.AW(ADDR_WIDTH)) u_map (
      .b          (b_d),
      .s          (s_d),
      .log_n      (ln_d),
      .mode       (mode_d),
      .addr_a     (map_a),
      .addr_b     (map_b),
      .tw_idx     (map_tw),
      .group_last (map_gl)
   );

   always_comb begin
      last_b_q = BW'((32'd1 << (32'(ln_q) - 32'd1)) - 32'd1);
      last_s_q = SW'(32'(ln_q) - 32'd1);
   end

   always_comb begin
      state_d = state_q;
      b_d     = b_q;
      s_d     = s_q;
      ln_d    = ln_q;
      mode_d  = mode_q;
      gap_d   = gap_q;
      valid_d = valid_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (log_n == '0)
                  ln_d = LW'(1);
               else if (32'(log_n) > ADDR_WIDTH)
                  ln_d = LW'(ADDR_WIDTH);
               else
                  ln_d = log_n;
               mode_d  = mode_e'(mode);
               b_d     = '0;
               s_d     = '0;
               valid_d = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (valid_q && out_ready) begin
               if (b_q != last_b_q) begin
                  b_d = b_q + BW'(1);
               end else if (s_q == last_s_q) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  b_d = '0;
                  s_d = s_q + SW'(1);
                  if (STAGE_GAP > 0) begin
                     valid_d = 1'b0;
                     gap_d   = GW'(STAGE_GAP - 1);
                     state_d = ST_GAP;
                  end
               end
            end
         end
         ST_GAP: begin
            if (gap_q == '0) begin
               valid_d = 1'b1;
               state_d = ST_RUN;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d   = (state_d != ST_IDLE);
      last_b_d = BW'((32'd1 << (32'(ln_d) - 32'd1)) - 32'd1);
      last_s_d = SW'(32'(ln_d) - 32'd1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         b_q     <= '0;
         s_q     <= '0;
         ln_q    <= LW'(1);
         mode_q  <= MODE_DIT;
         gap_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         s_q     <= s_d;
         ln_q    <= ln_d;
         mode_q  <= mode_d;
         gap_q   <= gap_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Beat registers only load when a beat is presented, so they stay frozen through stalls and idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_a_q     <= '0;
         addr_b_q     <= '0;
         tw_idx_q     <= '0;
         stage_q      <= '0;
         group_last_q <= 1'b0;
         out_last_q   <= 1'b0;
      end else if (valid_d) begin
         addr_a_q     <= map_a;
         addr_b_q     <= map_b;
         tw_idx_q     <= map_tw;
         stage_q      <= s_d;
         group_last_q <= map_gl;
         out_last_q   <= (b_d == last_b_d) && (s_d == last_s_d);
      end
   end

   assign busy       = busy_q;
   assign out_valid  = valid_q;
   assign done       = done_q;
   assign addr_a     = addr_a_q;
   assign addr_b     = addr_b_q;
   assign tw_idx     = tw_idx_q;
   assign stage      = stage_q;
   assign group_last = group_last_q;
   assign out_last   = out_last_q;

endmodule

// File: doc/fft_addr_gen.md
# fft_addr_gen

Sequential butterfly address generator for the shared-butterfly FFT. Once started, it walks every stage of a radix-2 FFT and emits one butterfly per accepted beat: the two operand addresses, a twiddle-table index and a group-boundary flag. It supports DIT and DIF ordering and any run-time size from 2 up to 2^ADDR_WIDTH points. It adds a ready/valid output and an idle gap between stages, so the butterfly pipeline can drain before the next stage starts. It sits between the FFT controller and the memory/twiddle-ROM read ports.

## Interface
- ADDR_WIDTH, 13, log2 of the maximum FFT size; also the data-memory address width.
- STAGE_GAP, 0, number of idle cycles inserted between stages. Legal range 0..255.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a transform
- log_n  in  $clog2(ADDR_WIDTH+1)  log2 of the FFT size; sampled when start is accepted
- mode  in  1  0 = DIT, 1 = DIF; sampled when start is accepted
- busy  out  1  high from the cycle after start is accepted until done
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts the beat
- addr_a  out  ADDR_WIDTH  upper-leg operand address
- addr_b  out  ADDR_WIDTH  lower-leg operand address, equal to addr_a | span
- tw_idx  out  ADDR_WIDTH-1  twiddle index into a table of 2^(ADDR_WIDTH-1) entries
- stage  out  $clog2(ADDR_WIDTH)  current stage number
- group_last  out  1  beat is the last butterfly of its group
- out_last  out  1  beat is the final butterfly of the transform
- done  out  1  one-cycle pulse after the final beat is accepted

## Operation
- State machine: IDLE, RUN, GAP.
  - IDLE, start=1 → RUN.
  - RUN, last beat of a stage accepted → GAP when STAGE_GAP>0 and more stages remain; otherwise go straight to the next stage.
  - GAP, counter expires → RUN.
  - RUN, final beat accepted → IDLE with done=1.
- start is ignored while busy.
- log_n is clamped: 0 → 1, values above ADDR_WIDTH → ADDR_WIDTH.
- Per stage s (0..log_n-1), the butterfly counter b runs 0..2^(log_n-1)-1.
- Bit position p:
  - DIT: p = s, span = 2^s.
  - DIF: p = log_n-1-s, span = 2^p.
- addr_a = b with a 0 inserted at bit p; addr_b sets that bit.
- Twiddle index, with j = b & (span-1):
  - DIT: tw_idx = j << (ADDR_WIDTH-1-s).
  - DIF: tw_idx = j << (s + ADDR_WIDTH - log_n).
- group_last = (j == span-1).
- out_last = last stage and last b.
- Address bits at or above log_n are always 0.

## Timing
- Reset values: IDLE, busy=0, out_valid=0, done=0; all address, index and flag outputs 0. Reset is effective asynchronously at any point, including mid-transform, and nothing is resumed after it.
- start seen in cycle t → busy=1 and the first beat valid in cycle t+1.
- All outputs are registered.
- Backpressure: while out_valid=1 and out_ready=0, every output holds stable.
- A beat transfers on out_valid & out_ready. The next beat is presented in the following cycle; throughput is one beat per cycle.
- GAP: out_valid=0 for exactly STAGE_GAP cycles.
- done and busy=0 appear in the cycle after the out_last transfer. A new start is accepted in that same cycle.
- Total cycles with out_ready held high: log_n·2^(log_n-1) + (log_n-1)·STAGE_GAP.

## Structure
- Shared package fft_addr_pkg holds:
  - the mode enum (MODE_DIT, MODE_DIF);
  - the state enum;
  - width helper functions for the stage and log_n fields.
- Sub-module fft_addr_map is purely combinational: (b, s, log_n, mode) → addr_a, addr_b, tw_idx, group_last. The top level holds the FSM, the counters and the output register.

## Test plan
- N=8, DIT, ADDR_WIDTH=13, ready always high, STAGE_GAP=0 → 12 beats.
  - Stage 0: pairs (0,1)(2,3)(4,5)(6,7), tw_idx 0.
  - Stage 1: pairs (0,2)(1,3)(4,6)(5,7), tw_idx 0,2048,0,2048, group_last on b=1 and b=3.
  - Stage 2: pairs (0,4)(1,5)(2,6)(3,7), tw_idx 0,1024,2048,3072.
  - done in cycle 13.
- N=8, DIF, STAGE_GAP=2.
  - Stage 0: pairs (0,4)..(3,7), tw_idx 0,1024,2048,3072.
  - Last stage: pairs (0,1)..(6,7), tw_idx 0.
  - Each of the 2 gaps has out_valid low for exactly 2 cycles; done in cycle 17.
- Random out_ready stalls on an N=16 DIT run → the accepted beat sequence is identical to the unstalled run, and outputs are stable during every stall.
- log_n=0 and log_n=1 → a single beat (0,1), tw_idx 0, out_last=1, group_last=1. log_n=15 → behaves as 13.
- start pulsed mid-run → ignored and the sequence is unaffected. rst_n low mid-stage → all outputs 0 immediately; the next start begins at stage 0, b=0.
- Back-to-back: start asserted in the done cycle → the new transform's first beat is valid in the next cycle.
